// File: rtl/alu_issue_pkg.sv
// Shared constants, width helpers and the default-layout entry record for the
// ALU reservation station.
package alu_issue_pkg;

   localparam int ENTRIES_DEF   = 8;
   localparam int NUM_FU_DEF    = 2;
   localparam int TAG_W_DEF     = 6;
   localparam int PAYLOAD_W_DEF = 32;
   localparam int EXT_WK_DEF    = 2;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int fu_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int FU_W_DEF = fu_w(NUM_FU_DEF);

   typedef struct packed {
      logic                     valid;
      logic [FU_W_DEF-1:0]      fu;
      logic [TAG_W_DEF-1:0]     src1_tag;
      logic [TAG_W_DEF-1:0]     src2_tag;
      logic                     rdy1;
      logic                     rdy2;
      logic                     dst_val;
      logic [TAG_W_DEF-1:0]     dst_tag;
      logic [PAYLOAD_W_DEF-1:0] payload;
   } rs_entry_t;

endpackage

// File: rtl/alu_issue_select_pick.sv
// Oldest-candidate picker: a candidate wins when no other candidate is older
// than it. The age matrix is a strict order, so at most one bit is granted.
module age_matrix_pick
   import alu_issue_pkg::*;
#(
   parameter int ENTRIES = ENTRIES_DEF
) (
   input  logic [ENTRIES-1:0]              i_cand,
   input  logic [ENTRIES-1:0][ENTRIES-1:0] i_older,
   output logic [ENTRIES-1:0]              o_grant,
   output logic                            o_any
);

   // Row i of i_older marks every entry that is older than entry i.
   always_comb begin
      o_grant = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         o_grant[i] = i_cand[i] & ~(|(i_cand & i_older[i]));
      end
   end

   assign o_any = |o_grant;

endmodule

// File: rtl/alu_issue_select.sv
// ALU reservation station with tag wakeup (external and self) and a registered
// oldest-first issue port per ALU.
module alu_issue_select
   import alu_issue_pkg::*;
#(
   parameter int  ENTRIES   = ENTRIES_DEF,
   parameter int  NUM_FU    = NUM_FU_DEF,
   parameter int  TAG_W     = TAG_W_DEF,
   parameter int  PAYLOAD_W = PAYLOAD_W_DEF,
   parameter int  EXT_WK    = EXT_WK_DEF,
   localparam int IDX_W     = idx_w(ENTRIES),
   localparam int FU_W      = fu_w(NUM_FU),
   localparam int CNT_W     = IDX_W + 1
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_flush,
   input  logic                        i_alloc_valid,
   output logic                        o_alloc_ready,
   input  logic [FU_W-1:0]             i_alloc_fu,
   input  logic [TAG_W-1:0]            i_alloc_src1_tag,
   input  logic [TAG_W-1:0]            i_alloc_src2_tag,
   input  logic                        i_alloc_src1_rdy,
   input  logic                        i_alloc_src2_rdy,
   input  logic                        i_alloc_dst_val,
   input  logic [TAG_W-1:0]            i_alloc_dst_tag,
   input  logic [PAYLOAD_W-1:0]        i_alloc_payload,
   input  logic [EXT_WK-1:0]           i_wk_valid,
   input  logic [EXT_WK*TAG_W-1:0]     i_wk_tag,
   input  logic [NUM_FU-1:0]           i_fu_stall,
   output logic [NUM_FU-1:0]           o_iss_valid,
   output logic [NUM_FU*PAYLOAD_W-1:0] o_iss_payload,
   output logic [NUM_FU-1:0]           o_iss_dst_val,
   output logic [NUM_FU*TAG_W-1:0]     o_iss_dst_tag,
   output logic [CNT_W-1:0]            o_count
);

   localparam int NSRC = EXT_WK + NUM_FU;

   typedef struct packed {
      logic                 valid;
      logic [FU_W-1:0]      fu;
      logic [TAG_W-1:0]     src1_tag;
      logic [TAG_W-1:0]     src2_tag;
      logic                 rdy1;
      logic                 rdy2;
      logic                 dst_val;
      logic [TAG_W-1:0]     dst_tag;
      logic [PAYLOAD_W-1:0] payload;
   } entry_t;

   entry_t                           r_ent [ENTRIES];
   logic [ENTRIES-1:0][ENTRIES-1:0]  r_older;
   logic [NUM_FU-1:0]                r_iss_valid;
   logic [NUM_FU-1:0][PAYLOAD_W-1:0] r_iss_payload;
   logic [NUM_FU-1:0]                r_iss_dst_val;
   logic [NUM_FU-1:0][TAG_W-1:0]     r_iss_dst_tag;

   logic [ENTRIES-1:0]               w_valid;
   logic [ENTRIES-1:0]               w_ent_rdy;
   logic [ENTRIES-1:0]               w_granted;
   logic [ENTRIES-1:0]               w_hit1;
   logic [ENTRIES-1:0]               w_hit2;
   logic [IDX_W-1:0]                 w_free_idx;
   logic [CNT_W-1:0]                 w_count;
   logic                             w_alloc_fire;
   logic                             w_alloc_hit1;
   logic                             w_alloc_hit2;
   logic [NUM_FU-1:0][ENTRIES-1:0]   w_cand;
   logic [NUM_FU-1:0][ENTRIES-1:0]   w_grant;
   logic [NUM_FU-1:0]                w_gany;
   logic [NUM_FU-1:0]                w_g_dst_val;
   logic [NUM_FU-1:0][PAYLOAD_W-1:0] w_g_payload;
   logic [NUM_FU-1:0][TAG_W-1:0]     w_g_dst_tag;
   logic [NSRC-1:0]                  w_src_vld;
   logic [NSRC-1:0][TAG_W-1:0]       w_src_tag;
   entry_t                           w_new;

   // Occupancy, readiness and lowest-index free slot (descending scan so the lowest wins).
   always_comb begin
      w_valid    = '0;
      w_ent_rdy  = '0;
      w_count    = '0;
      w_free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         w_valid[i]   = r_ent[i].valid;
         w_ent_rdy[i] = r_ent[i].valid & r_ent[i].rdy1 & r_ent[i].rdy2;
         w_count      = w_count + CNT_W'(r_ent[i].valid);
         w_free_idx   = r_ent[i].valid ? w_free_idx : IDX_W'(i);
      end
   end

   assign o_alloc_ready = ~(&w_valid);
   assign w_alloc_fire  = i_alloc_valid & o_alloc_ready & ~i_flush;
   assign o_count       = w_count;

   // Per-ALU candidate masks.
   always_comb begin
      w_cand = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         for (int i = 0; i < ENTRIES; i++) begin
            w_cand[k][i] = w_ent_rdy[i] & (r_ent[i].fu == FU_W'(k)) & ~i_fu_stall[k];
         end
      end
   end

   for (genvar k = 0; k < NUM_FU; k++) begin : g_pick
      age_matrix_pick #(.ENTRIES(ENTRIES)) u_pick (
         .i_cand  (w_cand[k]),
         .i_older (r_older),
         .o_grant (w_grant[k]),
         .o_any   (w_gany[k])
      );
   end

   // Granted-entry fields per ALU and the combined wakeup source list.
   always_comb begin
      w_granted   = '0;
      w_g_payload = '0;
      w_g_dst_val = '0;
      w_g_dst_tag = '0;
      w_src_vld   = '0;
      w_src_tag   = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         for (int i = 0; i < ENTRIES; i++) begin
            w_granted[i]   = w_granted[i] | w_grant[k][i];
            w_g_payload[k] = w_g_payload[k] | ({PAYLOAD_W{w_grant[k][i]}} & r_ent[i].payload);
            w_g_dst_val[k] = w_g_dst_val[k] | (w_grant[k][i] & r_ent[i].dst_val);
            w_g_dst_tag[k] = w_g_dst_tag[k] | ({TAG_W{w_grant[k][i]}} & r_ent[i].dst_tag);
         end
      end
      for (int s = 0; s < EXT_WK; s++) begin
         w_src_vld[s] = i_wk_valid[s];
         w_src_tag[s] = i_wk_tag[s*TAG_W +: TAG_W];
      end
      for (int k = 0; k < NUM_FU; k++) begin
         w_src_vld[EXT_WK+k] = w_gany[k] & w_g_dst_val[k];
         w_src_tag[EXT_WK+k] = w_g_dst_tag[k];
      end
   end

   // Tag match against resident entries and against the allocating op (bypass).
   always_comb begin
      w_hit1       = '0;
      w_hit2       = '0;
      w_alloc_hit1 = 1'b0;
      w_alloc_hit2 = 1'b0;
      for (int s = 0; s < NSRC; s++) begin
         for (int i = 0; i < ENTRIES; i++) begin
            w_hit1[i] = w_hit1[i] | (w_src_vld[s] & (r_ent[i].src1_tag == w_src_tag[s]));
            w_hit2[i] = w_hit2[i] | (w_src_vld[s] & (r_ent[i].src2_tag == w_src_tag[s]));
         end
         w_alloc_hit1 = w_alloc_hit1 | (w_src_vld[s] & (i_alloc_src1_tag == w_src_tag[s]));
         w_alloc_hit2 = w_alloc_hit2 | (w_src_vld[s] & (i_alloc_src2_tag == w_src_tag[s]));
      end
      w_new          = '0;
      w_new.valid    = 1'b1;
      w_new.fu       = i_alloc_fu;
      w_new.src1_tag = i_alloc_src1_tag;
      w_new.src2_tag = i_alloc_src2_tag;
      w_new.rdy1     = i_alloc_src1_rdy | w_alloc_hit1;
      w_new.rdy2     = i_alloc_src2_rdy | w_alloc_hit2;
      w_new.dst_val  = i_alloc_dst_val;
      w_new.dst_tag  = i_alloc_dst_tag;
      w_new.payload  = i_alloc_payload;
   end

   // Entry storage and age matrix; a new entry is younger than every resident one.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_ent[i] <= '0;
         end
         r_older <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_ent[i].valid <= 1'b0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_alloc_fire && (w_free_idx == IDX_W'(i))) begin
               r_ent[i]   <= w_new;
               r_older[i] <= w_valid;
            end else begin
               r_ent[i].valid <= r_ent[i].valid & ~w_granted[i];
               r_ent[i].rdy1  <= r_ent[i].rdy1 | w_hit1[i];
               r_ent[i].rdy2  <= r_ent[i].rdy2 | w_hit2[i];
            end
            if (w_alloc_fire) begin
               r_older[i][w_free_idx] <= 1'b0;
            end
         end
      end
   end

   // Issue ports: payload and destination hold their value when no grant.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_iss_valid   <= '0;
         r_iss_payload <= '0;
         r_iss_dst_val <= '0;
         r_iss_dst_tag <= '0;
      end else if (i_flush) begin
         r_iss_valid   <= '0;
         r_iss_payload <= '0;
         r_iss_dst_val <= '0;
         r_iss_dst_tag <= '0;
      end else begin
         for (int k = 0; k < NUM_FU; k++) begin
            r_iss_valid[k] <= w_gany[k];
            if (w_gany[k]) begin
               r_iss_payload[k] <= w_g_payload[k];
               r_iss_dst_val[k] <= w_g_dst_val[k];
               r_iss_dst_tag[k] <= w_g_dst_tag[k];
            end
         end
      end
   end

   assign o_iss_valid   = r_iss_valid;
   assign o_iss_payload = r_iss_payload;
   assign o_iss_dst_val = r_iss_dst_val;
   assign o_iss_dst_tag = r_iss_dst_tag;

endmodule

// File: tb/tb_alu_issue_select.sv
// Scoreboard bench: an age-ordered queue model predicts each grant, and a
// negedge monitor compares every DUT issue against the per-ALU expected queue.
module tb_alu_issue_select;
   import alu_issue_pkg::*;

   localparam int E  = 8;
   localparam int NF = 2;
   localparam int TW = 6;
   localparam int PW = 32;
   localparam int XW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             alloc_valid;
   logic             alloc_ready;
   logic [0:0]       alloc_fu;
   logic [TW-1:0]    alloc_src1_tag;
   logic [TW-1:0]    alloc_src2_tag;
   logic             alloc_src1_rdy;
   logic             alloc_src2_rdy;
   logic             alloc_dst_val;
   logic [TW-1:0]    alloc_dst_tag;
   logic [PW-1:0]    alloc_payload;
   logic [XW-1:0]    wk_valid;
   logic [XW*TW-1:0] wk_tag;
   logic [NF-1:0]    fu_stall;
   logic [NF-1:0]    iss_valid;
   logic [NF*PW-1:0] iss_payload;
   logic [NF-1:0]    iss_dst_val;
   logic [NF*TW-1:0] iss_dst_tag;
   logic [3:0]       count;

   alu_issue_select dut (
      .i_clk            (clk),
      .i_reset          (rst),
      .i_flush          (flush),
      .i_alloc_valid    (alloc_valid),
      .o_alloc_ready    (alloc_ready),
      .i_alloc_fu       (alloc_fu),
      .i_alloc_src1_tag (alloc_src1_tag),
      .i_alloc_src2_tag (alloc_src2_tag),
      .i_alloc_src1_rdy (alloc_src1_rdy),
      .i_alloc_src2_rdy (alloc_src2_rdy),
      .i_alloc_dst_val  (alloc_dst_val),
      .i_alloc_dst_tag  (alloc_dst_tag),
      .i_alloc_payload  (alloc_payload),
      .i_wk_valid       (wk_valid),
      .i_wk_tag         (wk_tag),
      .i_fu_stall       (fu_stall),
      .o_iss_valid      (iss_valid),
      .o_iss_payload    (iss_payload),
      .o_iss_dst_val    (iss_dst_val),
      .o_iss_dst_tag    (iss_dst_tag),
      .o_count          (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] payload;
      logic          dv;
      logic [TW-1:0] dt;
      int            cyc;
   } exp_t;

   rs_entry_t mq[$];
   exp_t      eq0[$];
   exp_t      eq1[$];
   exp_t      me;
   int        cyc = 0;
   int        n_cmp = 0;
   int        n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input int k, input exp_t e);
      if (k == 0) eq0.push_back(e);
      else        eq1.push_back(e);
   endtask

   // Monitor: every presented issue must match the head of that ALU's queue.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NF; k++) begin
            if (iss_valid[k]) begin
               if ((k == 0 && eq0.size() == 0) || (k == 1 && eq1.size() == 0)) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_issue fu%0d: got iss_valid=1 required 0 (cycle %0d)", k, cyc);
               end else begin
                  if (k == 0) me = eq0.pop_front();
                  else        me = eq1.pop_front();
                  chk("iss_payload", 64'(iss_payload[k*PW +: PW]), 64'(me.payload));
                  chk("iss_dst_val", 64'(iss_dst_val[k]), 64'(me.dv));
                  chk("iss_dst_tag", 64'(iss_dst_tag[k*TW +: TW]), 64'(me.dt));
                  chk("iss_cycle", 64'(cyc), 64'(me.cyc));
               end
            end
         end
      end
   end

   // Reference model: queue position is age; oldest ready entry per ALU wins.
   task automatic step();
      int        gidx [NF];
      bit [63:0] wm;
      rs_entry_t nq[$];
      rs_entry_t ne;
      exp_t      e;
      bit        keep;
      chk("alloc_ready", 64'(alloc_ready), 64'(mq.size() < E));
      chk("count", 64'(count), 64'(mq.size()));
      if (flush) begin
         mq.delete();
      end else begin
         wm = '0;
         for (int k = 0; k < NF; k++) begin
            gidx[k] = -1;
            if (!fu_stall[k]) begin
               for (int i = 0; i < mq.size(); i++) begin
                  if (gidx[k] < 0 && int'(mq[i].fu) == k && mq[i].rdy1 && mq[i].rdy2) gidx[k] = i;
               end
            end
         end
         for (int j = 0; j < XW; j++) begin
            if (wk_valid[j]) wm[wk_tag[j*TW +: TW]] = 1'b1;
         end
         for (int k = 0; k < NF; k++) begin
            if (gidx[k] >= 0) begin
               e.payload = mq[gidx[k]].payload;
               e.dv      = mq[gidx[k]].dst_val;
               e.dt      = mq[gidx[k]].dst_tag;
               e.cyc     = cyc + 1;
               push_exp(k, e);
               if (e.dv) wm[e.dt] = 1'b1;
            end
         end
         for (int i = 0; i < mq.size(); i++) begin
            keep = 1'b1;
            for (int k = 0; k < NF; k++) if (gidx[k] == i) keep = 1'b0;
            if (keep) begin
               ne = mq[i];
               if (wm[ne.src1_tag]) ne.rdy1 = 1'b1;
               if (wm[ne.src2_tag]) ne.rdy2 = 1'b1;
               nq.push_back(ne);
            end
         end
         if (alloc_valid && mq.size() < E) begin
            ne          = '0;
            ne.valid    = 1'b1;
            ne.fu       = alloc_fu;
            ne.src1_tag = alloc_src1_tag;
            ne.src2_tag = alloc_src2_tag;
            ne.rdy1     = alloc_src1_rdy | wm[alloc_src1_tag];
            ne.rdy2     = alloc_src2_rdy | wm[alloc_src2_tag];
            ne.dst_val  = alloc_dst_val;
            ne.dst_tag  = alloc_dst_tag;
            ne.payload  = alloc_payload;
            nq.push_back(ne);
         end
         mq = nq;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_alloc(input int fu, input int t1, input bit r1, input int t2, input bit r2,
                            input bit dv, input int dt);
      alloc_valid    = 1'b1;
      alloc_fu       = 1'(fu);
      alloc_src1_tag = TW'(t1);
      alloc_src1_rdy = r1;
      alloc_src2_tag = TW'(t2);
      alloc_src2_rdy = r2;
      alloc_dst_val  = dv;
      alloc_dst_tag  = TW'(dt);
      alloc_payload  = $urandom;
   endtask

   task automatic clr_in();
      alloc_valid = 1'b0;
      wk_valid    = '0;
      fu_stall    = '0;
      flush       = 1'b0;
   endtask

   task automatic idle(input int n);
      clr_in();
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst = 1'b1;
      clr_in();
      set_alloc(0, 0, 0, 0, 0, 0, 0);
      alloc_valid = 1'b0;
      wk_tag = '0;
      repeat (2) @(negedge clk);
      chk("rst_iss_valid", 64'(iss_valid), 64'd0);
      chk("rst_iss_payload", 64'(iss_payload), 64'd0);
      chk("rst_iss_dst_val", 64'(iss_dst_val), 64'd0);
      chk("rst_iss_dst_tag", 64'(iss_dst_tag), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
      rst = 1'b0;

      // Three ready ops to ALU0 on consecutive cycles.
      for (int i = 0; i < 3; i++) begin
         set_alloc(0, 1, 1, 2, 1, 0, 0);
         step();
      end
      idle(3);
      chk("drain3_count", 64'(count), 64'd0);

      // Producer/consumer chain through self-wakeup on ALU1.
      set_alloc(1, 0, 1, 0, 1, 1, 5);
      step();
      set_alloc(1, 5, 0, 0, 1, 0, 0);
      step();
      idle(3);

      // Fill with unready ops, wake all at once, try to allocate while full.
      for (int i = 0; i < E; i++) begin
         set_alloc(i % 2, 20, 0, 21, 0, 0, 0);
         step();
      end
      chk("full_ready", 64'(alloc_ready), 64'd0);
      set_alloc(0, 1, 1, 1, 1, 0, 0);
      wk_valid = 2'b11;
      wk_tag   = {6'd21, 6'd20};
      step();
      wk_valid = '0;
      step();
      chk("ready_after_issue", 64'(alloc_ready), 64'd1);
      idle(6);

      // ALU0 stalled for three cycles while ALU1 keeps issuing.
      set_alloc(0, 0, 1, 0, 1, 0, 0);
      step();
      fu_stall = 2'b01;
      set_alloc(0, 0, 1, 0, 1, 0, 0);
      step();
      set_alloc(1, 0, 1, 0, 1, 0, 0);
      step();
      alloc_valid = 1'b0;
      step();
      idle(4);

      // Allocation bypass from an external wakeup of the same tag.
      set_alloc(0, 9, 0, 3, 1, 0, 0);
      wk_valid = 2'b01;
      wk_tag   = {6'd0, 6'd9};
      step();
      idle(3);

      // Randomised traffic, then drain by sweeping wakeups over every tag.
      for (int c = 0; c < 400; c++) begin
         clr_in();
         if ($urandom_range(0, 3) != 0)
            set_alloc($urandom_range(0, 1), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 15));
         wk_valid    = 2'($urandom_range(0, 3));
         wk_tag      = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
         fu_stall[0] = ($urandom_range(0, 3) == 0);
         fu_stall[1] = ($urandom_range(0, 3) == 0);
         flush       = ($urandom_range(0, 99) == 0);
         step();
      end
      for (int c = 0; c < 40; c++) begin
         clr_in();
         wk_valid = 2'b11;
         wk_tag   = {6'((2 * c + 1) % 16), 6'((2 * c) % 16)};
         step();
      end
      idle(3);
      chk("random_drain_count", 64'(count), 64'd0);

      // Flush with five resident entries and a live issue.
      for (int i = 0; i < 5; i++) begin
         set_alloc(0, 30, 0, 30, 0, 0, 0);
         step();
      end
      set_alloc(1, 0, 1, 0, 1, 0, 0);
      step();
      idle(1);
      chk("pre_flush_issue", 64'(iss_valid[1]), 64'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_iss_valid", 64'(iss_valid), 64'd0);
      idle(2);

      // Asynchronous reset in the middle of traffic.
      set_alloc(0, 0, 1, 0, 1, 1, 7);
      step();
      set_alloc(0, 0, 1, 0, 1, 1, 8);
      step();
      clr_in();
      chk("pre_reset_issue", 64'(iss_valid[0]), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_iss_valid", 64'(iss_valid), 64'd0);
      chk("mid_rst_iss_payload", 64'(iss_payload), 64'd0);
      chk("mid_rst_iss_dst_tag", 64'(iss_dst_tag), 64'd0);
      chk("mid_rst_iss_dst_val", 64'(iss_dst_val), 64'd0);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_alloc_ready", 64'(alloc_ready), 64'd1);
      mq.delete();
      eq0.delete();
      eq1.delete();
      @(negedge clk);
      rst = 1'b0;
      idle(3);

      chk("pending_fu0", 64'(eq0.size()), 64'd0);
      chk("pending_fu1", 64'(eq1.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_select.md
# alu_issue_select

Parametrised ALU reservation station with registered oldest-first issue selection for the issue stage. It holds up to ENTRIES renamed ALU instructions. It tracks source readiness through tag wakeup, including same-cycle self-wakeup from its own grants. Each cycle it picks the oldest ready entry bound to each of NUM_FU ALUs and registers the winner into that ALU's issue port. It supersedes the fixed 8-entry / 2-ALU combinational selector.

## Interface
- ENTRIES, 8: reservation-station depth, power of two, ≥2.
- NUM_FU, 2: number of ALUs; each entry is bound to exactly one.
- TAG_W, 6: rename-register tag width (RRF_SEL).
- PAYLOAD_W, 32: opaque per-entry payload (opcode, immediates, PC).
- EXT_WK, 2: number of external wakeup ports.
- Derived: IDX_W = $clog2(ENTRIES); FU_W = max(1,$clog2(NUM_FU)); CNT_W = IDX_W+1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  sync clear of all entries and issue registers.
- alloc_valid  in  1  allocate request.
- alloc_ready  out  1  at least one free entry.
- alloc_fu  in  FU_W  target ALU.
- alloc_src1_tag, alloc_src2_tag  in  TAG_W  source tags.
- alloc_src1_rdy, alloc_src2_rdy  in  1  source already available.
- alloc_dst_val  in  1  writes a destination.
- alloc_dst_tag  in  TAG_W  destination tag.
- alloc_payload  in  PAYLOAD_W.
- wk_valid  in  EXT_WK  external wakeup strobes.
- wk_tag  in  EXT_WK*TAG_W  external wakeup tags.
- fu_stall  in  NUM_FU  ALU k cannot accept a new op next cycle.
- iss_valid  out  NUM_FU  registered issue strobe per ALU.
- iss_payload  out  NUM_FU*PAYLOAD_W.
- iss_dst_val  out  NUM_FU.
- iss_dst_tag  out  NUM_FU*TAG_W.
- count  out  CNT_W  occupied entries.

## Operation
- Per-entry state: valid, fu, src tags, rdy1/rdy2, dst_val/tag, payload.
- Age matrix older[i][j] means entry j is older than i.
- Allocation, when alloc_valid && alloc_ready && !flush:
  - Write into the lowest-index invalid entry.
  - Set older[new][j] = valid[j] for all j, and older[j][new] = 0.
- Entry i is a candidate for ALU k when valid, rdy1, rdy2, fu==k, !fu_stall[k] and not granted this cycle.
- Grant for ALU k goes to the candidate i with no other candidate j where older[i][j]. Result is one-hot or none.
- On grant:
  - The entry is invalidated at the edge.
  - Payload and dst are registered into ALU k's issue port, with iss_valid[k]=1.
  - Otherwise iss_valid[k]=0, and the other iss_* fields hold their previous values.
- Wakeup sources:
  - wk_valid/wk_tag.
  - Self-wakeup: dst tags of this cycle's grants with dst_val=1.
- A matching tag sets rdy1/rdy2 of every valid entry at the edge.
- The same match applied to alloc_src*_tag sets the written ready bit (allocation bypass).
- alloc_ready = !(all valid). It is computed from the current state only; slots freed this cycle are not visible.
- count = popcount(valid), combinational.

## Timing
- Reset (async) clears:
  - all valid, ready and older bits;
  - iss_valid=0, iss_payload=0, iss_dst_val=0, iss_dst_tag=0;
  - count=0 and alloc_ready=1.
- An entry allocated at edge t is selectable in cycle t+1, with iss_valid seen after edge t+1. This is the minimum alloc→issue latency of 2 edges.
- Back-to-back dependents: a producer granted in cycle c wakes its consumer at edge c. The consumer issues at edge c+1, i.e. one cycle apart.
- fu_stall[k] sampled in cycle c means no grant for k, so iss_valid[k]=0 after edge c. Its entries keep their age.
- flush has priority over alloc and grant. At the edge all valid=0 and iss_valid=0.
- Full with grant and alloc in the same cycle: alloc is refused (alloc_ready=0); the granted slot frees at that edge.
- A wakeup and an allocation of the same tag in the same cycle means the new entry is ready.
- Two entries with equal readiness are ordered by allocation order only, never by index.
- Reset asserted mid-operation discards all entries and the pending issue immediately.

## Structure
- Package alu_issue_pkg holds:
  - the default parameter constants;
  - the derived-width functions (idx_w, fu_w);
  - a packed typedef rs_entry_t {valid, fu, src1_tag, src2_tag, rdy1, rdy2, dst_val, dst_tag, payload}.
- Sub-module age_matrix_pick (ENTRIES): inputs are a candidate mask and the older matrix; output is a one-hot grant plus an any bit. Instantiate it NUM_FU times.
- The free-slot finder is a priority encoder inside the top module.

## Test plan
- Reset, then allocate 3 ready ops to ALU0 at cycles 0,1,2. Required: iss_valid[0] after edges 1,2,3, in allocation order; count returns to 0.
- Allocate entry A (dst tag 5), then B (src1 tag 5, rdy1=0) on ALU1. Required: A issues at edge n, B issues at edge n+1.
- Fill 8 entries with src rdy=0 in order, then wake all at once. Required: issue order per ALU matches allocation order; alloc_ready=0 while full, 1 after the first issue.
- Hold fu_stall[0]=1 for 3 cycles with 2 ready ALU0 entries. Required: iss_valid[0]=0 throughout, then the oldest issues first; ALU1 traffic is unaffected.
- Allocate with alloc_src1_tag=9 while wk_tag=9 is valid. Required: the entry is selectable the next cycle.
- Pulse flush with 5 entries and iss_valid=1. Required: count=0 and iss_valid=0 after the edge. Assert async reset mid-stream. Required: all outputs are at reset values before the next edge.
